// File: rtl/test_status_pkg.sv
// Shared definitions for the test-status peripheral.
//   state_e  : verdict FSM encoding (the 3-bit code is visible in STATUS reads)
//   bus_e    : bus handshake FSM encoding
//   OFF_*    : register byte offsets inside the 16-byte window
//   CTRL_RESTART : CTRL write bit that returns the block to RUN
package test_status_pkg;

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_PASS    = 3'd1,
    ST_FAIL    = 3'd2,
    ST_TIMEOUT = 3'd3
  } state_e;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_e;

  localparam logic [3:0] OFF_TESTNUM = 4'h0;
  localparam logic [3:0] OFF_STATUS  = 4'h4;
  localparam logic [3:0] OFF_CYCLES  = 4'h8;
  localparam logic [3:0] OFF_CTRL    = 4'hC;

  localparam int CTRL_RESTART = 0;

endpackage

// File: rtl/test_status_if.sv
// Data-bus slave port of the test-status peripheral.
//   req_i   : request, held by the master until ack_o
//   we_i    : 1 = write, 0 = read
//   addr_i  : byte address (word aligned)
//   wdata_i : write data
//   rdata_o : read data, non-zero only while ack_o=1
//   ack_o   : one-cycle acknowledge
interface test_status_if;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        ack_o;

  modport master (
    output req_i, we_i, addr_i, wdata_i,
    input  rdata_o, ack_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i,
    output rdata_o, ack_o
  );
endinterface

// File: rtl/test_status_dev.sv
// Memory-mapped test-status peripheral. The core writes the current test
// number and a verdict; the block latches them, runs a cycle watchdog and
// drives sideband status outputs for the simulation top.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-low reset
//   bus        : slave side of test_status_if (req/we/addr/wdata/rdata/ack)
//   done_o     : verdict reached (PASS, FAIL or TIMEOUT)
//   pass_o     : 1 only in PASS
//   timeout_o  : 1 only in TIMEOUT
//   testnum_o  : last TESTNUM written
//   cycles_o   : RUN cycle count
module test_status_dev
  import test_status_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter logic [31:0] TIMEOUT   = 32'd100000,
  parameter logic [31:0] PASS_CODE = 32'd1
) (
  input  logic               clk,
  input  logic               rst,
  test_status_if.slave       bus,
  output logic               done_o,
  output logic               pass_o,
  output logic               timeout_o,
  output logic [31:0]        testnum_o,
  output logic [31:0]        cycles_o
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  bus_e        bus_q, bus_d;
  state_e      state_q, state_d;
  logic [31:0] cycles_q, cycles_d;
  logic [31:0] fail_q, fail_d;
  logic [31:0] testnum_q, testnum_d;
  logic [31:0] rdata_q, rdata_d;

  logic       accept;
  logic       hit;
  logic [3:0] off;
  logic       wr;
  logic       wr_testnum;
  logic       wr_status;
  logic       wr_restart;

  // Decode stage: an access is accepted only while no ack is outstanding,
  // so every transfer costs exactly two cycles and the bus never stalls.
  always_comb begin
    accept     = bus.req_i && (bus_q == BUS_IDLE);
    hit        = (bus.addr_i[31:4] == BASE_ADDR[31:4]);
    off        = bus.addr_i[3:0];
    wr         = accept && bus.we_i && hit;
    wr_testnum = wr && (off == OFF_TESTNUM);
    wr_status  = wr && (off == OFF_STATUS);
    wr_restart = wr && (off == OFF_CTRL) && bus.wdata_i[CTRL_RESTART];
  end

  always_comb begin
    bus_d = BUS_IDLE;
    if (bus_q == BUS_IDLE && bus.req_i) begin
      bus_d = BUS_ACK;
    end
  end

  // Read data is captured at accept time; misses and writes return 0.
  always_comb begin
    rdata_d = 32'd0;
    if (accept && !bus.we_i && hit) begin
      case (off)
        OFF_TESTNUM: rdata_d = testnum_q;
        OFF_STATUS:  rdata_d = {27'd0, state_q, pass_o, done_o};
        OFF_CYCLES:  rdata_d = cycles_q;
        OFF_CTRL:    rdata_d = fail_q;
        default:     rdata_d = 32'd0;
      endcase
    end
  end

  always_comb begin
    testnum_d = wr_testnum ? bus.wdata_i : testnum_q;
  end

  // Verdict FSM and watchdog. A STATUS write beats the timeout in the same
  // cycle; the counter only advances while the block stays in RUN, so it
  // freezes at TIMEOUT-1 on a watchdog expiry.
  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    fail_d   = fail_q;
    if (wr_restart) begin
      state_d  = ST_RUN;
      cycles_d = 32'd0;
      fail_d   = 32'd0;
    end else if (state_q == ST_RUN) begin
      if (wr_status && bus.wdata_i == PASS_CODE) begin
        state_d = ST_PASS;
      end else if (wr_status && bus.wdata_i != 32'd0) begin
        state_d = ST_FAIL;
        fail_d  = bus.wdata_i;
      end else if (cycles_q == TIMEOUT - 32'd1) begin
        state_d = ST_TIMEOUT;
      end else begin
        cycles_d = sat_inc(cycles_q);
      end
    end
  end

  // Register stage: all state, including a pending acknowledge, is
  // discarded by reset; an interrupted master has to re-issue its request.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bus_q     <= BUS_IDLE;
      state_q   <= ST_RUN;
      cycles_q  <= 32'd0;
      fail_q    <= 32'd0;
      testnum_q <= 32'd0;
      rdata_q   <= 32'd0;
    end else begin
      bus_q     <= bus_d;
      state_q   <= state_d;
      cycles_q  <= cycles_d;
      fail_q    <= fail_d;
      testnum_q <= testnum_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.ack_o   = (bus_q == BUS_ACK);
  assign bus.rdata_o = rdata_q;
  assign done_o      = (state_q != ST_RUN);
  assign pass_o      = (state_q == ST_PASS);
  assign timeout_o   = (state_q == ST_TIMEOUT);
  assign testnum_o   = testnum_q;
  assign cycles_o    = cycles_q;

endmodule

// File: tb/tb_test_status_dev.sv
// Self-checking bench for test_status_dev (TIMEOUT=20). A driver issues bus
// transfers and pushes the expected read data into a scoreboard queue; a
// monitor pops and compares on every ack. Sideband outputs are checked
// directly by the stimulus thread.
module tb_test_status_dev;

  localparam logic [31:0] BASE = 32'h1000_0000;

  logic clk;
  logic rst;
  logic done_o, pass_o, timeout_o;
  logic [31:0] testnum_o, cycles_o;

  test_status_if bus ();

  test_status_dev #(
    .BASE_ADDR (BASE),
    .TIMEOUT   (32'd20),
    .PASS_CODE (32'd1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .done_o    (done_o),
    .pass_o    (pass_o),
    .timeout_o (timeout_o),
    .testnum_o (testnum_o),
    .cycles_o  (cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.ack_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_ack", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk(mon_e.name, bus.rdata_o, mon_e.rdata);
      end
    end
  end

  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rdata, input string name);
    exp_t e;
    e.rdata = exp_rdata;
    e.name  = name;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_i   = 1'b1;
    bus.we_i    = we;
    bus.addr_i  = addr;
    bus.wdata_i = wdata;
    @(posedge clk);
    @(negedge clk);
    chk({name, "_ack"}, {31'd0, bus.ack_o}, 32'd1);
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flags"}, {28'd0, bus.ack_o, done_o, pass_o, timeout_o}, 32'd0);
    chk({tag, "_testnum"}, testnum_o, 32'd0);
    chk({tag, "_cycles"}, cycles_o, 32'd0);
    chk({tag, "_rdata"}, bus.rdata_o, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    int n;
    rst         = 1'b0;
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
    bus.addr_i  = 32'd0;
    bus.wdata_i = 32'd0;

    // 1: TESTNUM then PASS
    do_reset();
    xfer(1'b1, BASE + 32'h0, 32'd5, 32'd0, "t1_wr_testnum");
    xfer(1'b1, BASE + 32'h4, 32'd1, 32'd0, "t1_wr_status");
    chk("t1_done", {31'd0, done_o}, 32'd1);
    chk("t1_pass", {31'd0, pass_o}, 32'd1);
    chk("t1_timeout", {31'd0, timeout_o}, 32'd0);
    chk("t1_testnum", testnum_o, 32'd5);
    xfer(1'b0, BASE + 32'h0, 32'd0, 32'd5, "t1_rd_testnum");
    xfer(1'b0, BASE + 32'h4, 32'd0, 32'h7, "t1_rd_status");

    // 2: FAIL verdict with code 7, later PASS ignored
    do_reset();
    xfer(1'b1, BASE + 32'h4, 32'h7, 32'd0, "t2_wr_status");
    chk("t2_done", {31'd0, done_o}, 32'd1);
    chk("t2_pass", {31'd0, pass_o}, 32'd0);
    xfer(1'b0, BASE + 32'hC, 32'd0, 32'h7, "t2_rd_ctrl");
    xfer(1'b1, BASE + 32'h4, 32'd1, 32'd0, "t2_wr_pass");
    xfer(1'b0, BASE + 32'h4, 32'd0, 32'h9, "t2_rd_status");
    chk("t2_pass_after", {31'd0, pass_o}, 32'd0);

    // 6a: restart from FAIL keeps TESTNUM
    xfer(1'b1, BASE + 32'h0, 32'h55, 32'd0, "t6_wr_testnum");
    xfer(1'b1, BASE + 32'hC, 32'd1, 32'd0, "t6_wr_ctrl");
    chk("t6_done", {31'd0, done_o}, 32'd0);
    chk("t6_testnum", testnum_o, 32'h55);
    chk("t6_cycles", cycles_o, 32'd0);
    xfer(1'b0, BASE + 32'h8, 32'd0, 32'd1, "t6_rd_cycles");
    xfer(1'b0, BASE + 32'hC, 32'd0, 32'd0, "t6_rd_ctrl");

    // 6b: reset asserted while a request is held
    @(negedge clk);
    rst         = 1'b0;
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b0;
    bus.addr_i  = BASE + 32'h4;
    @(posedge clk);
    @(negedge clk);
    chk_zero("t6_rst_req");
    @(posedge clk);
    @(negedge clk);
    chk("t6_rst_noack", {31'd0, bus.ack_o}, 32'd0);
    bus.req_i = 1'b0;
    rst       = 1'b1;

    // 5: CYCLES 10 cycles apart, out-of-window access
    do_reset();
    xfer(1'b0, BASE + 32'h8, 32'd0, 32'd1, "t5_rd_cycles_a");
    repeat (9) @(posedge clk);
    xfer(1'b0, BASE + 32'h8, 32'd0, 32'd11, "t5_rd_cycles_b");
    xfer(1'b1, BASE + 32'h20, 32'd1, 32'd0, "t5_wr_oow");
    xfer(1'b0, BASE + 32'h20, 32'd0, 32'd0, "t5_rd_oow");
    chk("t5_done", {31'd0, done_o}, 32'd0);
    chk("t5_testnum", testnum_o, 32'd0);

    // 3: watchdog expiry
    do_reset();
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (timeout_o === 1'b1) begin
        n = i;
        break;
      end
    end
    chk("t3_timeout_edge", n, 32'd20);
    chk("t3_cycles", cycles_o, 32'd19);
    repeat (5) @(posedge clk);
    #1;
    chk("t3_cycles_frozen", cycles_o, 32'd19);
    xfer(1'b1, BASE + 32'h4, 32'd1, 32'd0, "t3_wr_pass");
    xfer(1'b0, BASE + 32'h4, 32'd0, 32'hD, "t3_rd_status");
    chk("t3_pass", {31'd0, pass_o}, 32'd0);
    chk("t3_timeout", {31'd0, timeout_o}, 32'd1);

    // 4: PASS on the same edge as the watchdog would fire
    do_reset();
    repeat (19) @(posedge clk);
    xfer(1'b1, BASE + 32'h4, 32'd1, 32'd0, "t4_wr_status");
    chk("t4_pass", {31'd0, pass_o}, 32'd1);
    chk("t4_timeout", {31'd0, timeout_o}, 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("t4_timeout_later", {31'd0, timeout_o}, 32'd0);
    xfer(1'b0, BASE + 32'h4, 32'd0, 32'h7, "t4_rd_status");

    repeat (3) @(posedge clk);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
